uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO, runtime frame formatting and break generation. Sits between the bus-side UART register block and the `tx` pad. Accepts words over a valid/ready port, buffers up to `FIFO_DEPTH` of them, and serialises back-to-back frames at one bit per `clk_en_i` tick. Generalises the existing single-word transmitter with buffering, 5–`MAX_DATA_W` data bits, mark/space parity, break/mark-after-break and frame-done signalling.

---
 rtl/uart_tx_fifo.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated transmit FIFO.
// Frames are 1 start bit, 5..MAX_DATA_W data bits (LSB first), optional
// parity and 1 or 2 stop bits. The format is latched when a frame starts.
// Supports break generation followed by one mark-after-break bit period.
module uart_tx_fifo #(
    parameter  int MAX_DATA_W = 9,
    parameter  int FIFO_DEPTH = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clk_en_i,
    input  logic                  en_i,
    input  logic [3:0]            data_size_i,
    input  logic                  parity_en_i,
    input  logic [1:0]            parity_type_i,
    input  logic [1:0]            stop_size_i,
    input  logic                  break_i,
    input  logic                  flush_i,
    input  logic [MAX_DATA_W-1:0] wdata_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [LVL_W-1:0]      fifo_level_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Bits following the start bit: data + parity + two stops at most.
    localparam int SH_W  = MAX_DATA_W + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_BREAK,
        S_MAB
    } state_t;

    logic [MAX_DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  push, pop;

    state_t                state_q, state_d;
    logic [SH_W-1:0]       shreg_q, shreg_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  tx_q, tx_d;
    logic                  frame_done;

    logic [MAX_DATA_W-1:0] head;
    logic [3:0]            dsize;
    logic [SH_W-1:0]       payload;
    logic [3:0]            frame_len;
    logic                  par_acc, par_bit;
    logic                  start_ok;

    assign wready_o     = (level != LVL_W'(FIFO_DEPTH));
    assign push         = wvalid_i && wready_o;
    assign fifo_level_o = level;
    assign head         = mem[rd_ptr];
    assign tx_o         = tx_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = frame_done;
    // A flush in the same cycle would discard the pop, so no frame may start then.
    assign start_ok     = en_i && (level != '0) && !flush_i;

    // FIFO storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i && !flush_i) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // FIFO pointers and occupancy; push/flush act on every edge, pop only on ticks.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Build the post-start-bit payload (data, parity, stop ones) for the head word.
    always_comb begin
        if (data_size_i < 4'd5)                   dsize = 4'd5;
        else if (data_size_i > 4'(MAX_DATA_W))    dsize = 4'(MAX_DATA_W);
        else                                      dsize = data_size_i;
        payload = '1;
        par_acc = 1'b0;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            if (i < 32'(dsize)) begin
                payload[i] = head[i];
                par_acc    = par_acc ^ head[i];
            end
        end
        case (parity_type_i)
            2'd0:    par_bit = par_acc;
            2'd1:    par_bit = ~par_acc;
            2'd2:    par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
        if (parity_en_i) payload[dsize] = par_bit;
        frame_len = dsize + {3'b000, parity_en_i} + ((stop_size_i >= 2'd2) ? 4'd2 : 4'd1);
    end

    // State, shift register, bit counter and line register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            shreg_q <= '1;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state and datapath: cnt_q counts bits still to be placed on the line;
    // the tick seen with cnt_q == 0 ends the last stop bit.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        frame_done = 1'b0;
        if (clk_en_i) begin
            case (state_q)
                S_IDLE: begin
                    tx_d = 1'b1;
                    if (break_i) begin
                        state_d = S_BREAK;
                        tx_d    = 1'b0;
                    end else if (start_ok) begin
                        pop     = 1'b1;
                        state_d = S_SHIFT;
                        tx_d    = 1'b0;
                        shreg_d = payload;
                        cnt_d   = frame_len;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == '0) begin
                        frame_done = 1'b1;
                        if (break_i) begin
                            state_d = S_BREAK;
                            tx_d    = 1'b0;
                        end else if (start_ok) begin
                            pop     = 1'b1;
                            tx_d    = 1'b0;
                            shreg_d = payload;
                            cnt_d   = frame_len;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b1, shreg_q[SH_W-1:1]};
                        cnt_d   = cnt_q - 4'd1;
                    end
                end
                S_BREAK: begin
                    tx_d = 1'b0;
                    if (!break_i) begin
                        state_d = S_MAB;
                        tx_d    = 1'b1;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo. Ticks are one clk_en_i cycle
// followed by one idle cycle; line values are captured after each tick edge.
module tb_uart_tx_fifo;

    localparam int MAX_DATA_W = 9;
    localparam int FIFO_DEPTH = 16;
    localparam int LVL_W      = 5;

    logic                  clk = 1'b0;
    logic                  rst_i, clk_en_i, en_i, parity_en_i, break_i, flush_i, wvalid_i;
    logic [3:0]            data_size_i;
    logic [1:0]            parity_type_i, stop_size_i;
    logic [MAX_DATA_W-1:0] wdata_i;
    logic                  wready_o, tx_o, busy_o, frame_done_o;
    logic [LVL_W-1:0]      fifo_level_o;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_fifo #(.MAX_DATA_W(MAX_DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .clk_en_i(clk_en_i), .en_i(en_i),
        .data_size_i(data_size_i), .parity_en_i(parity_en_i),
        .parity_type_i(parity_type_i), .stop_size_i(stop_size_i),
        .break_i(break_i), .flush_i(flush_i), .wdata_i(wdata_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .fifo_level_o(fifo_level_o),
        .tx_o(tx_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic tick(output logic fd);
        clk_en_i = 1'b1;
        #1 fd = frame_done_o;
        @(negedge clk);
        clk_en_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic [8:0] d);
        wdata_i  = d;
        wvalid_i = 1'b1;
        @(negedge clk);
        wvalid_i = 1'b0;
    endtask

    task automatic collect(input int n, output logic [15:0] bits, output int fds);
        logic fd;
        bits = '0;
        fds  = 0;
        for (int i = 0; i < n; i++) begin
            tick(fd);
            bits[i] = tx_o;
            fds += int'(fd);
        end
    endtask

    task automatic set_fmt(input logic [3:0] s, input logic pe, input logic [1:0] pt, input logic [1:0] ss);
        data_size_i   = s;
        parity_en_i   = pe;
        parity_type_i = pt;
        stop_size_i   = ss;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (fifo_level_o !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level_o); end
        n_cmp++; if (wready_o !== 1'b1) begin n_bad++; $display("FAIL reset_wready: got %b want 1", wready_o); end
        n_cmp++; if (frame_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", frame_done_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_8n1;
        logic [15:0] bits;
        int fds, f2;
        logic fd;
        set_fmt(4'd8, 1'b0, 2'd0, 2'd0);
        en_i = 1'b1;
        push(9'h0A5);
        collect(10, bits, fds);
        n_cmp++; if (bits !== 16'h034A) begin n_bad++; $display("FAIL 8n1_bits: got %h want 034a", bits); end
        n_cmp++; if (fds !== 0) begin n_bad++; $display("FAIL 8n1_early_done: got %0d want 0", fds); end
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL 8n1_busy_mid: got %b want 1", busy_o); end
        tick(fd);
        n_cmp++; if (fd !== 1'b1) begin n_bad++; $display("FAIL 8n1_done: got %b want 1", fd); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL 8n1_busy_end: got %b want 0", busy_o); end
        n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL 8n1_idle_tx: got %b want 1", tx_o); end
        // format change after the start tick must not alter the frame in flight
        push(9'h0A5);
        collect(1, bits, fds);
        set_fmt(4'd5, 1'b1, 2'd2, 2'd3);
        collect(9, bits, f2);
        n_cmp++; if (bits !== 16'h01A5) begin n_bad++; $display("FAIL latch_fmt_bits: got %h want 01a5", bits); end
        tick(fd);
        n_cmp++; if (fd !== 1'b1) begin n_bad++; $display("FAIL latch_fmt_done: got %b want 1", fd); end
    endtask

    task automatic test_parity;
        logic [15:0] bits;
        int fds;
        logic fd;
        set_fmt(4'd7, 1'b1, 2'd0, 2'd2);
        push(9'h1FF);
        collect(11, bits, fds);
        n_cmp++; if (bits !== 16'h07FE) begin n_bad++; $display("FAIL 7e2_bits: got %h want 07fe", bits); end
        tick(fd);
        n_cmp++; if (fd !== 1'b1) begin n_bad++; $display("FAIL 7e2_done: got %b want 1", fd); end
        set_fmt(4'd7, 1'b1, 2'd1, 2'd1);
        push(9'h1FF);
        collect(10, bits, fds);
        n_cmp++; if (bits !== 16'h02FE) begin n_bad++; $display("FAIL 7o1_bits: got %h want 02fe", bits); end
        tick(fd);
        n_cmp++; if (fd !== 1'b1) begin n_bad++; $display("FAIL 7o1_done: got %b want 1", fd); end
    endtask

    task automatic test_size_clamp;
        logic [15:0] bits;
        int fds;
        logic fd;
        set_fmt(4'd2, 1'b1, 2'd0, 2'd0);
        push(9'h0E3);
        collect(8, bits, fds);
        n_cmp++; if (bits !== 16'h0086) begin n_bad++; $display("FAIL 5e1_clamp_bits: got %h want 0086", bits); end
        tick(fd);
        n_cmp++; if (fd !== 1'b1) begin n_bad++; $display("FAIL 5e1_clamp_done: got %b want 1", fd); end
        set_fmt(4'd15, 1'b0, 2'd0, 2'd0);
        push(9'h165);
        collect(11, bits, fds);
        n_cmp++; if (bits !== 16'h06CA) begin n_bad++; $display("FAIL 9n1_clamp_bits: got %h want 06ca", bits); end
        tick(fd);
        n_cmp++; if (fd !== 1'b1) begin n_bad++; $display("FAIL 9n1_clamp_done: got %b want 1", fd); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] bits, want;
        logic [LVL_W-1:0] lvl_seen;
        int fds;
        logic fd;
        set_fmt(4'd8, 1'b0, 2'd0, 2'd0);
        en_i = 1'b0;
        for (int k = 0; k < 16; k++) push(9'(48 + k));
        n_cmp++; if (fifo_level_o !== 5'd16) begin n_bad++; $display("FAIL full_level: got %0d want 16", fifo_level_o); end
        n_cmp++; if (wready_o !== 1'b0) begin n_bad++; $display("FAIL full_wready: got %b want 0", wready_o); end
        push(9'h1AA);
        n_cmp++; if (fifo_level_o !== 5'd16) begin n_bad++; $display("FAIL full_push_ignored: got %0d want 16", fifo_level_o); end
        en_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bits = '0;
            fds = 0;
            lvl_seen = '0;
            for (int j = 0; j < 10; j++) begin
                tick(fd);
                bits[j] = tx_o;
                if (j == 0) lvl_seen = fifo_level_o;
                fds += int'(fd);
            end
            want = {6'b0, 1'b1, 8'(48 + k), 1'b0};
            n_cmp++; if (bits !== want) begin n_bad++; $display("FAIL b2b_bits[%0d]: got %h want %h", k, bits, want); end
            n_cmp++; if (lvl_seen !== LVL_W'(15 - k)) begin n_bad++; $display("FAIL b2b_level[%0d]: got %0d want %0d", k, lvl_seen, 15 - k); end
            n_cmp++; if (fds !== ((k == 0) ? 0 : 1)) begin n_bad++; $display("FAIL b2b_done[%0d]: got %0d want %0d", k, fds, (k == 0) ? 0 : 1); end
        end
        tick(fd);
        n_cmp++; if (fd !== 1'b1) begin n_bad++; $display("FAIL b2b_last_done: got %b want 1", fd); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_flush;
        logic [15:0] bits;
        int fds;
        logic fd;
        set_fmt(4'd8, 1'b0, 2'd0, 2'd0);
        en_i = 1'b1;
        push(9'h03C); push(9'h011); push(9'h022); push(9'h033);
        tick(fd);
        n_cmp++; if (fifo_level_o !== 5'd3) begin n_bad++; $display("FAIL flush_pre_level: got %0d want 3", fifo_level_o); end
        flush_i  = 1'b1;
        wvalid_i = 1'b1;
        wdata_i  = 9'h044;
        @(negedge clk);
        flush_i  = 1'b0;
        wvalid_i = 1'b0;
        n_cmp++; if (fifo_level_o !== 5'd0) begin n_bad++; $display("FAIL flush_level: got %0d want 0", fifo_level_o); end
        collect(9, bits, fds);
        n_cmp++; if (bits !== 16'h013C) begin n_bad++; $display("FAIL flush_frame_bits: got %h want 013c", bits); end
        tick(fd);
        n_cmp++; if (fd !== 1'b1) begin n_bad++; $display("FAIL flush_done: got %b want 1", fd); end
        collect(3, bits, fds);
        n_cmp++; if (bits !== 16'h0007) begin n_bad++; $display("FAIL flush_idle_line: got %h want 0007", bits); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_break;
        logic [15:0] bits;
        int fds;
        logic fd;
        set_fmt(4'd8, 1'b0, 2'd0, 2'd0);
        en_i = 1'b1;
        push(9'h055); push(9'h00F);
        collect(4, bits, fds);
        n_cmp++; if (bits !== 16'h000A) begin n_bad++; $display("FAIL brk_head_bits: got %h want 000a", bits); end
        break_i = 1'b1;
        collect(6, bits, fds);
        n_cmp++; if (bits !== 16'h002A) begin n_bad++; $display("FAIL brk_tail_bits: got %h want 002a", bits); end
        tick(fd);
        n_cmp++; if (fd !== 1'b1) begin n_bad++; $display("FAIL brk_done: got %b want 1", fd); end
        n_cmp++; if (tx_o !== 1'b0) begin n_bad++; $display("FAIL brk_enter_tx: got %b want 0", tx_o); end
        collect(3, bits, fds);
        n_cmp++; if (bits !== 16'h0000) begin n_bad++; $display("FAIL brk_hold: got %h want 0000", bits); end
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL brk_busy: got %b want 1", busy_o); end
        n_cmp++; if (fifo_level_o !== 5'd1) begin n_bad++; $display("FAIL brk_level: got %0d want 1", fifo_level_o); end
        break_i = 1'b0;
        tick(fd);
        n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL mab_tx: got %b want 1", tx_o); end
        n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL mab_busy: got %b want 1", busy_o); end
        tick(fd);
        n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL mab_idle_tx: got %b want 1", tx_o); end
        collect(10, bits, fds);
        n_cmp++; if (bits !== 16'h021E) begin n_bad++; $display("FAIL brk_resume_bits: got %h want 021e", bits); end
        tick(fd);
        n_cmp++; if (fd !== 1'b1) begin n_bad++; $display("FAIL brk_resume_done: got %b want 1", fd); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] bits;
        int fds;
        logic fd;
        set_fmt(4'd8, 1'b0, 2'd0, 2'd0);
        en_i = 1'b1;
        push(9'h05A); push(9'h066);
        collect(6, bits, fds);
        n_cmp++; if (bits !== 16'h0034) begin n_bad++; $display("FAIL rst_pre_bits: got %h want 0034", bits); end
        rst_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid_tx: got %b want 1", tx_o); end
        n_cmp++; if (fifo_level_o !== 5'd0) begin n_bad++; $display("FAIL rst_mid_level: got %0d want 0", fifo_level_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
        n_cmp++; if (wready_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid_wready: got %b want 1", wready_o); end
        rst_i = 1'b0;
        collect(2, bits, fds);
        n_cmp++; if (bits !== 16'h0003) begin n_bad++; $display("FAIL rst_after_idle: got %h want 0003", bits); end
        set_fmt(4'd9, 1'b1, 2'd2, 2'd0);
        push(9'h000);
        collect(12, bits, fds);
        n_cmp++; if (bits !== 16'h0C00) begin n_bad++; $display("FAIL 9m1_bits: got %h want 0c00", bits); end
        tick(fd);
        n_cmp++; if (fd !== 1'b1) begin n_bad++; $display("FAIL 9m1_done: got %b want 1", fd); end
        set_fmt(4'd9, 1'b1, 2'd3, 2'd1);
        push(9'h1FF);
        collect(12, bits, fds);
        n_cmp++; if (bits !== 16'h0BFE) begin n_bad++; $display("FAIL 9s1_bits: got %h want 0bfe", bits); end
        tick(fd);
        n_cmp++; if (fd !== 1'b1) begin n_bad++; $display("FAIL 9s1_done: got %b want 1", fd); end
    endtask

    initial begin
        rst_i    = 1'b1;
        clk_en_i = 1'b0;
        en_i     = 1'b0;
        break_i  = 1'b0;
        flush_i  = 1'b0;
        wvalid_i = 1'b0;
        wdata_i  = '0;
        set_fmt(4'd8, 1'b0, 2'd0, 2'd0);
        @(negedge clk);
        test_reset();
        test_8n1();
        test_parity();
        test_size_clamp();
        test_back_to_back();
        test_flush();
        test_break();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
